vc_fifo_bank: RTL

//   Bank of NUM_VC independent virtual-channel FIFOs behind one shared write port.

---
 rtl/vc_fifo_bank.sv | 116 +++++++++++
 1 files changed

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent virtual-channel FIFOs sharing one write port.
// Each channel has its own read port, thresholds and sticky error flag.

// One virtual-channel FIFO: storage, pointers, occupancy, flags, error.
module vc_fifo_lane #(
    parameter int DW = 6,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          wr_req,
    input  logic [DW-1:0] data_in,
    input  logic          rd_req,
    input  logic [AW:0]   umbral,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          error
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          rd_acc, wr_acc, wr_err, rd_err;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    // Read decision uses pre-edge occupancy: no write-to-read bypass.
    assign rd_acc = rd_req && !empty;
    // A full channel still takes a write when a read frees a slot this cycle.
    assign wr_acc = wr_req && (!full || rd_acc);
    assign wr_err = wr_req && full && !rd_acc;
    assign rd_err = rd_req && empty;

    // cnt + umbral >= DEPTH in one extra bit avoids the DEPTH - umbral underflow.
    assign almost_full  = (({1'b0, cnt} + {1'b0, umbral}) >= (AW+2)'(DEPTH));
    assign almost_empty = (cnt <= umbral);

    // Storage write; memory contents survive clear.
    always_ff @(posedge clk) begin
        if (wr_acc && !clear)
            mem[wr_ptr] <= data_in;
    end

    // Pointers, occupancy, registered read data and sticky error.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            data_out   <= rd_acc ? mem[rd_ptr] : '0;
            data_valid <= rd_acc;
            error      <= error | wr_err | rd_err;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module vc_fifo_bank #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 2,
    parameter int NUM_VC       = 2,
    parameter int VC_SEL_WIDTH = $clog2(NUM_VC)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             init,
    input  logic                             wr_enable,
    input  logic [VC_SEL_WIDTH-1:0]          wr_vc,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [NUM_VC-1:0]                rd_enable,
    input  logic [NUM_VC*(ADDR_WIDTH+1)-1:0] umbral,
    output logic [NUM_VC*DATA_WIDTH-1:0]     data_out,
    output logic [NUM_VC-1:0]                data_valid,
    output logic [NUM_VC-1:0]                full,
    output logic [NUM_VC-1:0]                empty,
    output logic [NUM_VC-1:0]                almost_full,
    output logic [NUM_VC-1:0]                almost_empty,
    output logic [NUM_VC-1:0]                error
);
    logic clear;
    assign clear = reset | init;

    // A wr_vc outside 0..NUM_VC-1 matches no lane and is dropped silently.
    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        vc_fifo_lane #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_lane (
            .clk          (clk),
            .clear        (clear),
            .wr_req       (wr_enable && (wr_vc == VC_SEL_WIDTH'(i))),
            .data_in      (data_in),
            .rd_req       (rd_enable[i]),
            .umbral       (umbral[i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]),
            .data_out     (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .data_valid   (data_valid[i]),
            .full         (full[i]),
            .empty        (empty[i]),
            .almost_full  (almost_full[i]),
            .almost_empty (almost_empty[i]),
            .error        (error[i])
        );
    end
endmodule
